// File: rtl/flex_pts_pkg.sv
// Shared types and helpers for the handshaked flexible parallel-to-serial shifter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package flex_pts_pkg;

  typedef enum logic {
    PTS_IDLE  = 1'b0,
    PTS_SHIFT = 1'b1
  } pts_state_t;

  // Bit-counter width for a word of n bits; never narrower than one bit.
  function automatic int pts_cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pts_hold_reg.sv
// One-entry holding register (word + direction) with a full flag.
// Latency: written data is readable the cycle after wr.
// Backpressure: owner must only write when !full and only read when full.
//
// Ports:
//   clk, n_rst   clock, asynchronous active-low reset
//   clear        synchronous flush, empties the register
//   wr, wr_dat   write strobe and data
//   rd           read strobe (empties the register)
//   full         register holds a word
//   rd_dat       held data
module pts_hold_reg #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         wr,
  input  logic [W-1:0] wr_dat,
  input  logic         rd,
  output logic         full,
  output logic [W-1:0] rd_dat
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      full   <= 1'b0;
      rd_dat <= '0;
    end else if (clear) begin
      full   <= 1'b0;
      rd_dat <= '0;
    end else if (wr) begin
      full   <= 1'b1;
      rd_dat <= wr_dat;
    end else if (rd) begin
      full   <= 1'b0;
    end
  end

endmodule

// File: rtl/flex_pts_sr_hs.sv
// Handshaked parallel-to-serial shifter with a one-word skid register.
// Latency: first bit on serial_out the cycle after the handshake; one bit per shift_enable.
// Backpressure: data_ready = !hold_full (registered); a word in flight plus one held word.
//
// Ports:
//   clk, n_rst            clock, asynchronous active-low reset
//   clear                 synchronous flush of all state (drops held word, no word_done)
//   shift_enable          bit strobe
//   data_in, msb_first    word and its direction, taken on data_valid & data_ready
//   data_valid/ready      input handshake
//   serial_out            current bit, IDLE_BIT when idle
//   busy                  a word is being serialised
//   word_done             one-cycle pulse after the last bit of a word shifts out
module flex_pts_sr_hs
  import flex_pts_pkg::*;
#(
  parameter int   NUM_BITS = 8,
  parameter logic IDLE_BIT = 1'b1,
  parameter int   CNT_W    = pts_cnt_width(NUM_BITS)
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                shift_enable,
  input  logic [NUM_BITS-1:0] data_in,
  input  logic                msb_first,
  input  logic                data_valid,
  output logic                data_ready,
  output logic                serial_out,
  output logic                busy,
  output logic                word_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pts_state_t          state;
  logic [NUM_BITS-1:0] sr;
  logic [CNT_W-1:0]    cnt;
  logic                cur_msb;

  logic                hs;
  logic                last_bit;
  logic                hold_full;
  logic                hold_wr;
  logic                hold_rd;
  logic [NUM_BITS:0]   hold_dat;

  assign data_ready = !hold_full;
  assign hs         = data_valid & data_ready;
  assign last_bit   = (state == PTS_SHIFT) & shift_enable & (cnt == '0);

  // Words only go to the holding register while another word is shifting;
  // in IDLE the shift register is loaded directly.
  assign hold_wr = hs & !clear & (state == PTS_SHIFT);
  // Drain the holding register either at the last bit (gapless) or from IDLE
  // when a word was captured on the very edge the previous word finished.
  assign hold_rd = !clear & hold_full & ((state == PTS_IDLE) | last_bit);

  pts_hold_reg #(
    .W (NUM_BITS + 1)
  ) u_hold (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (clear),
    .wr     (hold_wr),
    .wr_dat ({msb_first, data_in}),
    .rd     (hold_rd),
    .full   (hold_full),
    .rd_dat (hold_dat)
  );

  assign busy       = (state == PTS_SHIFT);
  assign serial_out = (state == PTS_SHIFT) ? (cur_msb ? sr[NUM_BITS-1] : sr[0]) : IDLE_BIT;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= PTS_IDLE;
      sr        <= {NUM_BITS{IDLE_BIT}};
      cnt       <= '0;
      cur_msb   <= 1'b0;
      word_done <= 1'b0;
    end else if (clear) begin
      state     <= PTS_IDLE;
      sr        <= {NUM_BITS{IDLE_BIT}};
      cnt       <= '0;
      cur_msb   <= 1'b0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      case (state)
        PTS_IDLE: begin
          if (hold_full) begin
            sr      <= hold_dat[NUM_BITS-1:0];
            cur_msb <= hold_dat[NUM_BITS];
            cnt     <= CNT_MAX;
            state   <= PTS_SHIFT;
          end else if (hs) begin
            sr      <= data_in;
            cur_msb <= msb_first;
            cnt     <= CNT_MAX;
            state   <= PTS_SHIFT;
          end
        end
        PTS_SHIFT: begin
          if (shift_enable) begin
            if (cnt != '0) begin
              // Move the next bit toward the output end, back-filling idle.
              sr  <= cur_msb ? {sr[NUM_BITS-2:0], IDLE_BIT} : {IDLE_BIT, sr[NUM_BITS-1:1]};
              cnt <= cnt - CNT_ONE;
            end else begin
              word_done <= 1'b1;
              if (hold_full) begin
                sr      <= hold_dat[NUM_BITS-1:0];
                cur_msb <= hold_dat[NUM_BITS];
                cnt     <= CNT_MAX;
              end else begin
                sr    <= {NUM_BITS{IDLE_BIT}};
                state <= PTS_IDLE;
              end
            end
          end
        end
        default: state <= PTS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flex_pts_sr_hs.sv
// Self-checking bench for flex_pts_sr_hs (NUM_BITS=8, IDLE_BIT=1).
// Reference model keeps the in-flight word as a queue of bits in output order
// and the held word in a one-deep queue; each strobe pops one bit.
module tb_flex_pts_sr_hs;

  localparam int   N  = 8;
  localparam logic IB = 1'b1;

  logic         clk, n_rst, clear, shift_enable, msb_first, data_valid;
  logic [N-1:0] data_in;
  logic         data_ready, serial_out, busy, word_done;

  int n_vec = 0;
  int n_err = 0;

  flex_pts_sr_hs #(.NUM_BITS(N), .IDLE_BIT(IB)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .shift_enable (shift_enable),
    .data_in      (data_in),
    .msb_first    (msb_first),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .serial_out   (serial_out),
    .busy         (busy),
    .word_done    (word_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic         m_cur[$];
  logic [N:0]   m_pend[$];
  logic         m_in_shift;
  logic         m_wd;

  function automatic void model_reset();
    m_cur.delete();
    m_pend.delete();
    m_in_shift = 1'b0;
    m_wd       = 1'b0;
  endfunction

  function automatic void model_load(input logic [N:0] w);
    m_cur.delete();
    for (int i = 0; i < N; i++) m_cur.push_back(w[N] ? w[N-1-i] : w[i]);
    m_in_shift = 1'b1;
  endfunction

  // {serial_out, busy, data_ready, word_done}
  function automatic logic [3:0] m_out();
    logic s;
    s = m_in_shift ? m_cur[0] : IB;
    return {s, m_in_shift, (m_pend.size() == 0), m_wd};
  endfunction

  function automatic logic [3:0] d_out();
    return {serial_out, busy, data_ready, word_done};
  endfunction

  // Drive one cycle of inputs, advance model across the edge, sample #1 later.
  task automatic step(input logic v, input logic [N-1:0] d, input logic m,
                      input logic se, input logic clr, output logic acc);
    logic hs, had;
    data_valid   = v;
    data_in      = d;
    msb_first    = m;
    shift_enable = se;
    clear        = clr;
    @(posedge clk);
    hs   = v && (m_pend.size() == 0);
    acc  = hs && !clr;
    m_wd = 1'b0;
    if (clr) begin
      model_reset();
    end else if (!m_in_shift) begin
      if (m_pend.size() != 0) model_load(m_pend.pop_front());
      else if (hs)            model_load({m, d});
    end else begin
      had = (m_pend.size() != 0);
      if (se) begin
        void'(m_cur.pop_front());
        if (m_cur.size() == 0) begin
          m_wd = 1'b1;
          if (had) model_load(m_pend.pop_front());
          else     m_in_shift = 1'b0;
        end
      end
      if (hs) m_pend.push_back({m, d});
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic acc;
    n_vec++;
    if (d_out() !== 4'b1010) begin
      n_err++; $display("FAIL reset_state: got %b exp %b", d_out(), 4'b1010);
    end
    n_rst = 1'b1;
    model_reset();
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, acc);
    n_vec++;
    if (d_out() !== m_out()) begin
      n_err++; $display("FAIL reset_pre: got %b exp %b", d_out(), m_out());
    end
    #3 n_rst = 1'b0;
    #1;
    n_vec++;
    if (d_out() !== 4'b1010) begin
      n_err++; $display("FAIL reset_async: got %b exp %b", d_out(), 4'b1010);
    end
    data_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_rst = 1'b1;
    model_reset();
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 8'h00, 1'b0, c[0], 1'b0, acc);
      n_vec++;
      if (d_out() !== m_out() || serial_out !== 1'b1) begin
        n_err++; $display("FAIL idle_strobe step %0d: got %b exp %b", c, d_out(), m_out());
      end
    end
  endtask

  task automatic test_lsb_single();
    logic acc;
    logic [7:0] got;
    int wd_cnt;
    got = '0; wd_cnt = 0;
    for (int c = 0; c < 11; c++) begin
      step(c == 0, 8'hA5, 1'b0, 1'b1, 1'b0, acc);
      if (c < 8) got[c] = serial_out;
      if (word_done) wd_cnt++;
      n_vec++;
      if (d_out() !== m_out()) begin
        n_err++; $display("FAIL lsb_cycle step %0d: got %b exp %b", c, d_out(), m_out());
      end
      if (c == 8) begin
        n_vec++;
        if (d_out() !== 4'b1011) begin
          n_err++; $display("FAIL lsb_done: got %b exp %b", d_out(), 4'b1011);
        end
      end
    end
    n_vec++;
    if (got !== 8'hA5 || wd_cnt != 1) begin
      n_err++; $display("FAIL lsb_stream: got %b/%0d exp %b/1", got, wd_cnt, 8'hA5);
    end
  endtask

  task automatic test_msb_sparse();
    logic acc;
    logic [7:0] got;
    int wd_cnt;
    got = '0; wd_cnt = 0;
    for (int c = 0; c < 36; c++) begin
      step(c == 0, 8'h3C, 1'b1, (c % 4) == 3, 1'b0, acc);
      if ((c % 4) == 1 && c < 32) got[c / 4] = serial_out;
      if (word_done) wd_cnt++;
      n_vec++;
      if (d_out() !== m_out()) begin
        n_err++; $display("FAIL msb_cycle step %0d: got %b exp %b", c, d_out(), m_out());
      end
    end
    n_vec++;
    if (got !== 8'b0011_1100 || wd_cnt != 1) begin
      n_err++; $display("FAIL msb_stream: got %b/%0d exp %b/1", got, wd_cnt, 8'b0011_1100);
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    logic [15:0] got;
    int w1, w2;
    got = '0; w1 = -1; w2 = -1;
    for (int c = 0; c < 20; c++) begin
      if (c == 0)      step(1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, acc);
      else if (c == 1) step(1'b1, 8'hF0, 1'b1, 1'b1, 1'b0, acc);
      else             step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);
      if (c < 16) got[c] = serial_out;
      if (word_done) begin
        if (w1 < 0) w1 = c; else w2 = c;
      end
      n_vec++;
      if (d_out() !== m_out()) begin
        n_err++; $display("FAIL b2b_cycle step %0d: got %b exp %b", c, d_out(), m_out());
      end
      if (c >= 1 && c <= 8) begin
        n_vec++;
        if (data_ready !== (c == 8)) begin
          n_err++; $display("FAIL b2b_ready step %0d: got %b exp %b", c, data_ready, c == 8);
        end
      end
    end
    n_vec++;
    if (got !== 16'h0F0F || w1 != 8 || w2 != 16) begin
      n_err++; $display("FAIL b2b_stream: got %h wd %0d,%0d exp %h wd 8,16", got, w1, w2, 16'h0F0F);
    end
  endtask

  task automatic test_backpressure();
    logic acc;
    logic [23:0] got, exp;
    logic [7:0] w [3];
    logic       md [3];
    int acc_at, c, k;
    w = '{8'h12, 8'h34, 8'h55};
    md = '{1'b0, 1'b1, 1'b0};
    k = 0;
    for (int i = 0; i < 3; i++)
      for (int b = 0; b < 8; b++) begin
        exp[k] = md[i] ? w[i][7-b] : w[i][b];
        k++;
      end
    got = '0; acc_at = -1; c = 0;
    step(1'b1, w[0], md[0], 1'b1, 1'b0, acc); got[0] = serial_out; c = 1;
    step(1'b1, w[1], md[1], 1'b1, 1'b0, acc); got[1] = serial_out; c = 2;
    while (acc_at < 0 && c < 22) begin
      step(1'b1, w[2], md[2], 1'b1, 1'b0, acc);
      if (acc) acc_at = c;
      got[c] = serial_out;
      n_vec++;
      if (d_out() !== m_out()) begin
        n_err++; $display("FAIL bp_cycle step %0d: got %b exp %b", c, d_out(), m_out());
      end
      c++;
    end
    n_vec++;
    if (acc_at != 9) begin
      n_err++; $display("FAIL bp_accept: got step %0d exp step 9", acc_at);
    end
    while (c < 28) begin
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);
      if (c < 24) got[c] = serial_out;
      n_vec++;
      if (d_out() !== m_out()) begin
        n_err++; $display("FAIL bp_cycle step %0d: got %b exp %b", c, d_out(), m_out());
      end
      c++;
    end
    n_vec++;
    if (got !== exp) begin
      n_err++; $display("FAIL bp_stream: got %h exp %h", got, exp);
    end
  endtask

  task automatic test_clear();
    logic acc;
    step(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, acc);
    step(1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, acc);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);
    step(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, acc);
    n_vec++;
    if (d_out() !== 4'b1010 || d_out() !== m_out()) begin
      n_err++; $display("FAIL clear_state: got %b exp %b", d_out(), 4'b1010);
    end
    for (int c = 0; c < 12; c++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc);
      n_vec++;
      if (d_out() !== 4'b1010) begin
        n_err++; $display("FAIL clear_after step %0d: got %b exp %b", c, d_out(), 4'b1010);
      end
    end
  endtask

  task automatic test_random();
    logic acc, se, v, clr;
    int errs;
    errs = 0;
    for (int blk = 0; blk < 10; blk++) begin
      for (int c = 0; c < 60; c++) begin
        v   = ($urandom % 3) != 0;
        se  = blk[0] ? 1'b1 : (($urandom % 3) == 0);
        clr = ($urandom % 80) == 0;
        step(v, 8'($urandom), 1'($urandom), se, clr, acc);
        n_vec++;
        if (d_out() !== m_out()) begin
          n_err++; errs++;
          if (errs < 10)
            $display("FAIL random blk %0d step %0d: got %b exp %b", blk, c, d_out(), m_out());
        end
      end
    end
  endtask

  initial begin
    n_rst = 1'b0; clear = 1'b0; shift_enable = 1'b0;
    data_valid = 1'b0; data_in = '0; msb_first = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_lsb_single();
    test_msb_sparse();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
